// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter family: channel count,
// index width and the arbiter FSM state encoding.
package arb_pkg;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and rr_arbiter4.
// master: requester side (drives req/done); slave: arbiter side.
interface rr_arbiter4_if;
    import arb_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              done;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_valid;
    logic              timeout_pulse;

    modport master (
        output req,
        output done,
        input  grant_idx,
        input  grant_valid,
        input  timeout_pulse
    );

    modport slave (
        input  req,
        input  done,
        output grant_idx,
        output grant_valid,
        output timeout_pulse
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: finds the first requesting channel after
// last_ptr, wrapping around. Purely combinational.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_ptr,
    output logic [IDX_W-1:0]  pick,
    output logic              any
);

    logic [IDX_W-1:0] idx;

    // Scan last_ptr+1 .. last_ptr+NUM_CH; the first set request wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = last_ptr + IDX_W'(k);
            if (!any && req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-channel round-robin arbiter with hold-until-done grant.
// Optional forced release after HOLD_MAX grant cycles when the macro
// RR_ARB_TIMEOUT_EN is defined; otherwise timeout_pulse is tied low.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter4_if.slave bus
);

    if (HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_bad_hold
        $error("rr_arbiter4: HOLD_MAX must be in 1..65535");
    end

    state_t           state;
    logic [IDX_W-1:0] last_ptr;
    logic [IDX_W-1:0] grant_idx_q;
    logic             grant_valid_q;
    logic [IDX_W-1:0] pick;
    logic             any;
    logic             release_now;

    rr_pick u_pick (
        .req      (bus.req),
        .last_ptr (last_ptr),
        .pick     (pick),
        .any      (any)
    );

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_hit;
    logic             timeout_q;

    // done wins over a simultaneous timeout, so the pulse only fires without done.
    assign timeout_hit = (state == GRANT) && !bus.done && (hold_cnt == CNT_MAX);
    assign release_now = bus.done || timeout_hit;

    // Hold counter: zero in IDLE, counts GRANT cycles without done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state == IDLE || release_now) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.timeout_pulse = timeout_q;
`else
    assign release_now       = bus.done;
    assign bus.timeout_pulse = 1'b0;
`endif

    // Arbiter FSM: arbitrate in IDLE, hold the grant until release.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            state         <= IDLE;
            last_ptr      <= 2'b11;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        grant_idx_q   <= pick;
                        grant_valid_q <= 1'b1;
                        state         <= GRANT;
                    end else begin
                        grant_valid_q <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant_valid_q <= 1'b0;
                        last_ptr      <= grant_idx_q;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_idx   = grant_idx_q;
    assign bus.grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4. Inputs change 1 ns after
// the rising edge; outputs are sampled at the same point.
// Define RR_ARB_TIMEOUT_EN to exercise the forced-release build.
module tb_rr_arbiter4;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 255;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_arbiter4_if bus ();

    rr_arbiter4 #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        int held;
        int tp_seen;
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        bus.done = 1'b0;

        // Reset state
        #12;
        check("rst_idx", int'(bus.grant_idx), 0);
        check("rst_valid", int'(bus.grant_valid), 0);
        check("rst_tp", int'(bus.timeout_pulse), 0);
        rst_n = 1'b1;
        tick();

        // All requesting: 0,1,2,3,0 with one idle cycle between grants
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_idx%0d", i), int'(bus.grant_idx), exp_seq[i]);
            check($sformatf("rr_valid%0d", i), int'(bus.grant_valid), 1);
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            check($sformatf("rr_gap%0d", i), int'(bus.grant_valid), 0);
            if (i == 4) bus.req = 4'b0000;
        end
        tick();
        check("idle_noreq", int'(bus.grant_valid), 0);

        // Grant 1, then req=0101 picks 2, then wraps to 0
        bus.req = 4'b0010;
        tick();
        check("g1_idx", int'(bus.grant_idx), 1);
        bus.req  = 4'b0000;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 4'b0101;
        tick();
        check("p0101_idx", int'(bus.grant_idx), 2);
        check("p0101_valid", int'(bus.grant_valid), 1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("p0101_gapidx", int'(bus.grant_idx), 2);
        tick();
        check("wrap_idx", int'(bus.grant_idx), 0);
        check("wrap_valid", int'(bus.grant_valid), 1);
        bus.req  = 4'b0000;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;

        // Grant 3, drop its request; grant must persist
        bus.req = 4'b1000;
        tick();
        check("g3_idx", int'(bus.grant_idx), 3);
        bus.req = 4'b0000;
        held = 0;
        for (int i = 0; i < ((HOLD < 10) ? HOLD : 10); i++) begin
            tick();
            if (bus.grant_valid === 1'b1 && bus.grant_idx === 2'd3) held++;
        end
        check("g3_hold", held, (HOLD < 10) ? HOLD : 10);

        // Asynchronous reset mid-grant
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", int'(bus.grant_valid), 0);
        check("async_idx", int'(bus.grant_idx), 0);
        bus.req = 4'b1000;
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_1000", int'(bus.grant_idx), 3);
        check("post_rst_1000v", int'(bus.grant_valid), 1);
        #3;
        rst_n = 1'b0;
        bus.req = 4'b1001;
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_1001", int'(bus.grant_idx), 0);
        check("post_rst_1001v", int'(bus.grant_valid), 1);

`ifdef RR_ARB_TIMEOUT_EN
        // Counter reaches HOLD after HOLD further cycles; release on the next edge
        held = 0;
        for (int i = 0; i < HOLD; i++) begin
            tick();
            if (bus.grant_valid === 1'b1) held++;
        end
        check("to_held", held, HOLD);
        tick();
        check("to_release", int'(bus.grant_valid), 0);
        check("to_pulse", int'(bus.timeout_pulse), 1);
        tick();
        check("to_pulse_end", int'(bus.timeout_pulse), 0);
        check("to_next_idx", int'(bus.grant_idx), 3);
        check("to_next_valid", int'(bus.grant_valid), 1);
`else
        // No timeout: grant held 100 cycles, pulse never seen
        held    = 0;
        tp_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.grant_valid === 1'b1 && bus.grant_idx === 2'd0) held++;
            if (bus.timeout_pulse !== 1'b0) tp_seen++;
        end
        check("hold100", held, 100);
        check("no_timeout", tp_seen, 0);
        bus.done = 1'b1;
        bus.req  = 4'b0010;
        tick();
        bus.done = 1'b0;
        check("done_req_gap", int'(bus.grant_valid), 0);
        tick();
        check("done_req_idx", int'(bus.grant_idx), 1);
        check("done_req_valid", int'(bus.grant_valid), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
